// File: rtl/gbt_deframer_pkg.sv
// Shared definitions for the GBT downlink request deframer: frame state
// encoding, elink word field positions and the default trailer code.
package gbt_deframer_pkg;

  // One state per word position of a 7-word request frame, plus HUNT for
  // searching the stream for a trailer code.
  typedef enum logic [2:0] {
    HUNT = 3'd0,
    HDR  = 3'd1,
    A1   = 3'd2,
    A2   = 3'd3,
    D0   = 3'd4,
    D1   = 3'd5,
    D2   = 3'd6,
    TRL  = 3'd7
  } state_t;

  // Fast TTC bits ride in the top nibble of every elink word.
  localparam int TTC_L1A_BIT      = 15;
  localparam int TTC_CALPULSE_BIT = 14;
  localparam int TTC_RESYNC_BIT   = 13;
  localparam int TTC_BC0_BIT      = 12;

  // Payload field (everything below the TTC nibble).
  localparam int PAYLOAD_MSB = 11;
  localparam int PAYLOAD_LSB = 0;

  // Header flags.
  localparam int WR_VALID_BIT = 11;
  localparam int WR_EN_BIT    = 10;

  // Reserved bits that must be zero: header [9:8], first data word [11:8].
  localparam int HDR_RSVD_MSB = 9;
  localparam int HDR_RSVD_LSB = 8;
  localparam int D0_RSVD_MSB  = 11;
  localparam int D0_RSVD_LSB  = 8;

  // Low byte carried by the header (addr[31:24]) and by D0 (data[31:24]).
  localparam int BYTE_MSB = 7;
  localparam int BYTE_LSB = 0;

  // Trailer code marking the end of every frame.
  localparam logic [11:0] DEFAULT_FRAME_END = 12'hABC;

  // Width of the good-frame counter; large enough for LOCK_FRAMES up to 15.
  localparam int GOOD_CNT_WIDTH = 4;

endpackage

// File: rtl/gbt_request_deframer.sv
// GBT downlink deframer: decodes the per-word TTC bits and rebuilds 7-word
// request frames (HDR, A1, A2, D0, D1, D2, TRL) into 32-bit address/data
// write requests. Tracks frame sync and counts framing errors.
module gbt_request_deframer
  import gbt_deframer_pkg::*;
#(
  parameter logic [11:0] FRAME_END     = DEFAULT_FRAME_END,
  parameter int          LOCK_FRAMES   = 2,
  parameter int          ERR_CNT_WIDTH = 16
) (
  input  logic                     ttc_clk_40_i,
  input  logic                     reset_i,
  input  logic [15:0]              gbt_rx_data_i,
  output logic                     l1a_o,
  output logic                     calpulse_o,
  output logic                     resync_o,
  output logic                     bc0_o,
  output logic                     req_en_o,
  output logic                     req_wr_o,
  output logic [31:0]              req_addr_o,
  output logic [31:0]              req_data_o,
  output logic                     locked_o,
  output logic [ERR_CNT_WIDTH-1:0] frame_err_cnt_o
);

  localparam logic [GOOD_CNT_WIDTH-1:0] LOCK_CNT = GOOD_CNT_WIDTH'(LOCK_FRAMES);

  // Frame state and sync tracking
  state_t                      r_state;
  state_t                      w_state_next;
  logic [GOOD_CNT_WIDTH-1:0]   r_good_cnt;
  logic                        r_locked;
  logic [ERR_CNT_WIDTH-1:0]    r_err_cnt;

  // Holding registers filled as the frame streams in
  logic                        r_hold_wr_valid;
  logic                        r_hold_wr_en;
  logic [31:0]                 r_hold_addr;
  logic [31:0]                 r_hold_data;

  // Registered outputs
  logic [3:0]                  r_ttc;
  logic                        r_req_en;
  logic                        r_req_wr;
  logic [31:0]                 r_req_addr;
  logic [31:0]                 r_req_data;

  // Decode helpers
  logic [11:0]                 w_payload;
  logic                        w_frame_err;
  logic                        w_frame_good;
  logic                        w_emit;
  logic [GOOD_CNT_WIDTH-1:0]   w_good_cnt_next;
  logic                        w_locked_next;
  logic [ERR_CNT_WIDTH-1:0]    w_err_cnt_next;

  assign w_payload = gbt_rx_data_i[PAYLOAD_MSB:PAYLOAD_LSB];

  // State register: HUNT out of reset, otherwise follow the word sequencer
  always_ff @(posedge ttc_clk_40_i) begin
    if (reset_i) begin
      r_state <= HUNT;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic: advance one state per word, drop to HUNT on any framing error
  always_comb begin
    w_state_next = r_state;
    w_frame_err  = 1'b0;
    w_frame_good = 1'b0;
    case (r_state)
      HUNT: begin
        // A trailer code seen while hunting only marks alignment; it is not a frame.
        if (w_payload == FRAME_END) begin
          w_state_next = HDR;
        end
      end
      HDR: begin
        if (gbt_rx_data_i[HDR_RSVD_MSB:HDR_RSVD_LSB] != 2'b00) begin
          w_frame_err  = 1'b1;
          w_state_next = HUNT;
        end else begin
          w_state_next = A1;
        end
      end
      A1: w_state_next = A2;
      A2: w_state_next = D0;
      D0: begin
        if (gbt_rx_data_i[D0_RSVD_MSB:D0_RSVD_LSB] != 4'h0) begin
          w_frame_err  = 1'b1;
          w_state_next = HUNT;
        end else begin
          w_state_next = D1;
        end
      end
      D1: w_state_next = D2;
      D2: w_state_next = TRL;
      TRL: begin
        if (w_payload == FRAME_END) begin
          w_frame_good = 1'b1;
          w_state_next = HDR;
        end else begin
          w_frame_err  = 1'b1;
          w_state_next = HUNT;
        end
      end
      default: w_state_next = HUNT;
    endcase
  end

  // Output/bookkeeping logic: lock counting, error counter saturation, emission decision
  always_comb begin
    w_good_cnt_next = r_good_cnt;
    w_locked_next   = r_locked;
    w_err_cnt_next  = r_err_cnt;
    // Lock is judged on the state before this trailer, so the frame that
    // achieves lock is not itself emitted.
    w_emit          = w_frame_good & r_locked & r_hold_wr_valid;
    if (w_frame_err) begin
      w_good_cnt_next = '0;
      w_locked_next   = 1'b0;
      if (r_err_cnt != {ERR_CNT_WIDTH{1'b1}}) begin
        w_err_cnt_next = r_err_cnt + 1'b1;
      end
    end else if (w_frame_good) begin
      if (r_good_cnt != LOCK_CNT) begin
        w_good_cnt_next = r_good_cnt + 1'b1;
      end
      if (w_good_cnt_next == LOCK_CNT) begin
        w_locked_next = 1'b1;
      end
    end
  end

  // Sync tracking registers: good-frame count, lock flag, saturating error count
  always_ff @(posedge ttc_clk_40_i) begin
    if (reset_i) begin
      r_good_cnt <= '0;
      r_locked   <= 1'b0;
      r_err_cnt  <= '0;
    end else begin
      r_good_cnt <= w_good_cnt_next;
      r_locked   <= w_locked_next;
      r_err_cnt  <= w_err_cnt_next;
    end
  end

  // Field capture: each frame word deposits its slice into the holding registers
  always_ff @(posedge ttc_clk_40_i) begin
    if (reset_i) begin
      r_hold_wr_valid <= 1'b0;
      r_hold_wr_en    <= 1'b0;
      r_hold_addr     <= '0;
      r_hold_data     <= '0;
    end else begin
      case (r_state)
        HDR: begin
          r_hold_wr_valid     <= gbt_rx_data_i[WR_VALID_BIT];
          r_hold_wr_en        <= gbt_rx_data_i[WR_EN_BIT];
          r_hold_addr[31:24]  <= gbt_rx_data_i[BYTE_MSB:BYTE_LSB];
        end
        A1: r_hold_addr[23:12] <= w_payload;
        A2: r_hold_addr[11:0]  <= w_payload;
        D0: r_hold_data[31:24] <= gbt_rx_data_i[BYTE_MSB:BYTE_LSB];
        D1: r_hold_data[23:12] <= w_payload;
        D2: r_hold_data[11:0]  <= w_payload;
        default: ;
      endcase
    end
  end

  // Output registers: TTC bits every word, request fields only on emission
  always_ff @(posedge ttc_clk_40_i) begin
    if (reset_i) begin
      r_ttc      <= 4'h0;
      r_req_en   <= 1'b0;
      r_req_wr   <= 1'b0;
      r_req_addr <= '0;
      r_req_data <= '0;
    end else begin
      r_ttc    <= {gbt_rx_data_i[TTC_L1A_BIT], gbt_rx_data_i[TTC_CALPULSE_BIT],
                   gbt_rx_data_i[TTC_RESYNC_BIT], gbt_rx_data_i[TTC_BC0_BIT]};
      r_req_en <= w_emit;
      if (w_emit) begin
        r_req_wr   <= r_hold_wr_en;
        r_req_addr <= r_hold_addr;
        r_req_data <= r_hold_data;
      end
    end
  end

  assign l1a_o           = r_ttc[3];
  assign calpulse_o      = r_ttc[2];
  assign resync_o        = r_ttc[1];
  assign bc0_o           = r_ttc[0];
  assign req_en_o        = r_req_en;
  assign req_wr_o        = r_req_wr;
  assign req_addr_o      = r_req_addr;
  assign req_data_o      = r_req_data;
  assign locked_o        = r_locked;
  assign frame_err_cnt_o = r_err_cnt;

endmodule
